register_file: RTL and testbench

Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer's commit port and upstream of operand fetch in the processor. It accepts in-order commits of (address, value, tag) from the ROB and rename requests from the issue stage. Each cycle it returns registered operand values, or the pending ROB tag, for two source registers. It is the only holder of architectural state and of the "register waits on tag" map.

---
 rtl/register_file.sv | 112 +++++++++++
 tb/tb_register_file.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags: in-order ROB commits,
// issue-stage renames, flush recovery, and two registered read ports with commit bypass.
module register_file #(
    parameter int REG_NUM   = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 commit_valid,
    input  logic [4:0]           commit_addr,
    input  logic [31:0]          commit_value,
    input  logic [TAG_WIDTH-1:0] commit_tag,
    input  logic                 issue_valid,
    input  logic [4:0]           issue_rd,
    input  logic [TAG_WIDTH-1:0] issue_tag,
    input  logic                 flush,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [31:0]          rs1_value,
    output logic [31:0]          rs2_value,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [TAG_WIDTH-1:0] rs1_tag,
    output logic [TAG_WIDTH-1:0] rs2_tag
);

    typedef struct packed {
        logic [31:0]          value;
        logic                 busy;
        logic [TAG_WIDTH-1:0] tag;
    } read_t;

    logic [31:0]          value_q [REG_NUM];
    logic [REG_NUM-1:0]   busy_q;
    logic [TAG_WIDTH-1:0] tag_q   [REG_NUM];

    logic [REG_NUM-1:0]   commit_hit;
    logic [REG_NUM-1:0]   clear_hit;
    logic [REG_NUM-1:0]   issue_hit;

    read_t                rd1;
    read_t                rd2;

    // Entry 0 is never decoded, so x0 keeps its reset contents forever.
    always_comb begin
        commit_hit = '0;
        clear_hit  = '0;
        issue_hit  = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            commit_hit[i] = commit_valid && (commit_addr == 5'(i));
            clear_hit[i]  = commit_hit[i] && busy_q[i] && (tag_q[i] == commit_tag);
            issue_hit[i]  = issue_valid && !flush && (issue_rd == 5'(i));
        end
    end

    // Read view: after the same-cycle commit, before the same-cycle issue.
    function automatic read_t read_port(input logic [4:0] addr);
        read_t r;
        r = '0;
        if (addr != 5'd0) begin
            r.value = commit_hit[addr] ? commit_value : value_q[addr];
            r.busy  = busy_q[addr] && !clear_hit[addr] && !flush;
            r.tag   = r.busy ? tag_q[addr] : '0;
        end
        return r;
    endfunction

    always_comb begin
        rd1 = read_port(rs1_addr);
        rd2 = read_port(rs2_addr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q    <= '0;
            rs1_value <= '0;
            rs2_value <= '0;
            rs1_busy  <= 1'b0;
            rs2_busy  <= 1'b0;
            rs1_tag   <= '0;
            rs2_tag   <= '0;
        end else if (rdy) begin
            for (int i = 1; i < REG_NUM; i++) begin
                if (commit_hit[i]) begin
                    value_q[i] <= commit_value;
                end
                // A newer rename always beats the clear of an older one.
                if (flush) begin
                    busy_q[i] <= 1'b0;
                    tag_q[i]  <= '0;
                end else if (issue_hit[i]) begin
                    busy_q[i] <= 1'b1;
                    tag_q[i]  <= issue_tag;
                end else if (clear_hit[i]) begin
                    busy_q[i] <= 1'b0;
                end
            end
            rs1_value <= rd1.value;
            rs1_busy  <= rd1.busy;
            rs1_tag   <= rd1.tag;
            rs2_value <= rd2.value;
            rs2_busy  <= rd2.busy;
            rs2_tag   <= rd2.tag;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: directed scenarios plus randomized traffic
// checked against an array-based model of the architectural/rename state.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        commit_valid = 1'b0;
    logic [4:0]  commit_addr = '0;
    logic [31:0] commit_value = '0;
    logic [3:0]  commit_tag = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [3:0]  issue_tag = '0;
    logic        flush = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_value, rs2_value;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;

    register_file #(.REG_NUM(32), .TAG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .commit_valid(commit_valid), .commit_addr(commit_addr),
        .commit_value(commit_value), .commit_tag(commit_tag),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
        .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] v1;
        logic        b1;
        logic [3:0]  t1;
        logic [31:0] v2;
        logic        b2;
        logic [3:0]  t2;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        last_exp = '0;
    logic [31:0] mv [32];
    logic        mb [32];
    logic [3:0]  mt [32];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req)
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        else
            n_pass++;
    endtask

    // Architectural view of register a as an instruction issued this cycle would see it.
    task automatic model_read(input logic [4:0] a, output logic [31:0] v, output logic b,
                              output logic [3:0] t);
        v = 32'd0; b = 1'b0; t = 4'd0;
        if (a != 5'd0) begin
            v = mv[a];
            b = mb[a];
            if (commit_valid && commit_addr == a) begin
                v = commit_value;
                if (mb[a] && mt[a] == commit_tag) b = 1'b0;
            end
            if (flush) b = 1'b0;
            t = b ? mt[a] : 4'd0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mv[i] = 32'd0; mb[i] = 1'b0; mt[i] = 4'd0;
        end
    endtask

    // Predict the outputs of the coming edge, advance the model, then run the edge.
    task automatic tick();
        exp_t e;
        if (rst) begin
            e = '0;
            model_reset();
        end else if (!rdy) begin
            e = last_exp;
        end else begin
            model_read(rs1_addr, e.v1, e.b1, e.t1);
            model_read(rs2_addr, e.v2, e.b2, e.t2);
            if (commit_valid && commit_addr != 5'd0) begin
                mv[commit_addr] = commit_value;
                if (mb[commit_addr] && mt[commit_addr] == commit_tag) mb[commit_addr] = 1'b0;
            end
            if (flush) begin
                for (int i = 0; i < 32; i++) begin
                    mb[i] = 1'b0; mt[i] = 4'd0;
                end
            end else if (issue_valid && issue_rd != 5'd0) begin
                mb[issue_rd] = 1'b1;
                mt[issue_rd] = issue_tag;
            end
        end
        last_exp = e;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op(input logic cv, input logic [4:0] ca, input logic [31:0] cval,
                      input logic [3:0] ct, input logic iv, input logic [4:0] ird,
                      input logic [3:0] it, input logic fl, input logic [4:0] r1,
                      input logic [4:0] r2);
        commit_valid = cv; commit_addr = ca; commit_value = cval; commit_tag = ct;
        issue_valid = iv; issue_rd = ird; issue_tag = it; flush = fl;
        rs1_addr = r1; rs2_addr = r2;
        tick();
    endtask

    // Monitor: every edge produces one registered response.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_rs1_value", rs1_value, e.v1);
            chk("sb_rs1_busy", 32'(rs1_busy), 32'(e.b1));
            chk("sb_rs1_tag", 32'(rs1_tag), 32'(e.t1));
            chk("sb_rs2_value", rs2_value, e.v2);
            chk("sb_rs2_busy", 32'(rs2_busy), 32'(e.b2));
            chk("sb_rs2_tag", 32'(rs2_tag), 32'(e.t2));
        end
    end

    initial begin
        logic [4:0] a;
        model_reset();
        @(negedge clk);
        rst = 1'b1; rdy = 1'b1;
        tick();
        rst = 1'b0;

        op(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        chk("reset_x5_value", rs1_value, 32'd0);
        chk("reset_x5_busy", 32'(rs1_busy), 32'd0);
        chk("reset_x0_tag", 32'(rs2_tag), 32'd0);

        op(0, 0, 0, 0, 1, 5, 3, 0, 5, 0);
        chk("own_rd_old_mapping", 32'(rs1_busy), 32'd0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        chk("issue_x5_busy", 32'(rs1_busy), 32'd1);
        chk("issue_x5_tag", 32'(rs1_tag), 32'd3);
        op(1, 5, 32'hDEADBEEF, 3, 0, 0, 0, 0, 5, 0);
        chk("bypass_x5_value", rs1_value, 32'hDEADBEEF);
        chk("bypass_x5_busy", 32'(rs1_busy), 32'd0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        chk("commit_x5_value", rs1_value, 32'hDEADBEEF);
        chk("commit_x5_busy", 32'(rs1_busy), 32'd0);

        op(0, 0, 0, 0, 1, 7, 2, 0, 0, 0);
        op(0, 0, 0, 0, 1, 7, 9, 0, 0, 0);
        op(1, 7, 32'h11, 2, 0, 0, 0, 0, 7, 0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        chk("stale_x7_value", rs1_value, 32'h11);
        chk("stale_x7_busy", 32'(rs1_busy), 32'd1);
        chk("stale_x7_tag", 32'(rs1_tag), 32'd9);
        op(1, 7, 32'h22, 9, 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        chk("match_x7_value", rs1_value, 32'h22);
        chk("match_x7_busy", 32'(rs1_busy), 32'd0);

        op(0, 0, 0, 0, 1, 4, 1, 0, 0, 0);
        op(1, 4, 32'h55, 1, 1, 4, 6, 0, 4, 0);
        chk("same_cycle_x4_value", rs1_value, 32'h55);
        chk("same_cycle_x4_busy", 32'(rs1_busy), 32'd0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        chk("issue_wins_x4_busy", 32'(rs1_busy), 32'd1);
        chk("issue_wins_x4_tag", 32'(rs1_tag), 32'd6);

        op(1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 1, 3, 5, 0, 0, 0);
        op(0, 0, 0, 0, 1, 8, 6, 0, 0, 0);
        op(0, 0, 0, 0, 1, 9, 7, 1, 3, 8);
        chk("flush_fwd_x3_busy", 32'(rs1_busy), 32'd0);
        chk("flush_fwd_x8_busy", 32'(rs2_busy), 32'd0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 9, 3);
        chk("flush_drop_x9_busy", 32'(rs1_busy), 32'd0);
        chk("flush_x3_value", rs2_value, 32'h33);
        chk("flush_x3_busy", 32'(rs2_busy), 32'd0);
        op(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
        chk("x0_value", rs1_value, 32'd0);
        chk("flush_x8_busy", 32'(rs2_busy), 32'd0);

        op(1, 2, 32'h12, 0, 0, 0, 0, 0, 2, 0);
        rdy = 1'b0;
        op(1, 2, 32'h99, 0, 1, 2, 5, 0, 2, 5);
        op(1, 2, 32'h99, 0, 1, 2, 5, 0, 2, 5);
        chk("hold_rs1_value", rs1_value, 32'h12);
        chk("hold_rs2_value", rs2_value, 32'd0);
        rdy = 1'b1;
        op(1, 2, 32'h99, 0, 0, 0, 0, 0, 2, 0);
        chk("resume_bypass_x2", rs1_value, 32'h99);
        op(0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
        chk("resume_x2_value", rs1_value, 32'h99);

        op(0, 0, 0, 0, 1, 6, 4, 0, 0, 0);
        rst = 1'b1; rdy = 1'b0;
        op(1, 5, 32'h77, 0, 1, 5, 1, 1, 5, 6);
        chk("midreset_value", rs1_value, 32'd0);
        rst = 1'b0; rdy = 1'b1;
        op(0, 0, 0, 0, 0, 0, 0, 0, 5, 6);
        chk("after_reset_x5_value", rs1_value, 32'd0);
        chk("after_reset_x6_busy", 32'(rs2_busy), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            commit_valid = $urandom_range(0, 1);
            a = 5'($urandom_range(0, 7));
            commit_addr = a;
            commit_value = $urandom;
            commit_tag = ($urandom_range(0, 2) != 0 && mb[a]) ? mt[a] : 4'($urandom);
            issue_valid = $urandom_range(0, 1);
            issue_rd = 5'($urandom_range(0, 7));
            issue_tag = 4'($urandom);
            flush = ($urandom_range(0, 24) == 0);
            rs1_addr = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            rs2_addr = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            tick();
        end

        rst = 1'b0; rdy = 1'b1;
        op(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain_timeout actual=%0d required=0 responses outstanding", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
